reservation_station_entry_gen: RTL and testbench

RESERVATION_STATION_ENTRY_GEN -- requirements
Module: reservation_station_entry_gen

---
 rtl/reservation_station_entry_gen.sv | 135 +++++++++++++
 tb/tb_reservation_station_entry_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_entry_gen.sv
// reservation_station_entry_gen: one reservation-station entry with CDB operand wakeup and in-order ex-pointer gating.
// Define RS_ENTRY_AGE_EN to add the saturating oINFO_AGE wait counter.
module reservation_station_entry_gen #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 2,
  parameter int N_CDB  = 3,
  parameter int REG_W  = 6,
  parameter int TAG_W  = 6,
  parameter int CMD_W  = 5,
  parameter int PTR_W  = 4
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iREMOVE_VALID,
  input  logic                    iEXOUT_VALID,
  input  logic                    iREGIST_VALID,
  input  logic [CMD_W-1:0]        iREGIST_CMD,
  input  logic [REG_W-1:0]        iREGIST_DEST_REGNAME,
  input  logic                    iREGIST_DEST_SYSREG,
  input  logic [TAG_W-1:0]        iREGIST_COMMIT_TAG,
  input  logic [31:0]             iREGIST_PC,
  input  logic [PTR_W-1:0]        iREGIST_EX_POINTER,
  input  logic [N_SRC-1:0]        iREGIST_SRC_VALID,
  input  logic [N_SRC-1:0]        iREGIST_SRC_SYSREG,
  input  logic [N_SRC*DATA_W-1:0] iREGIST_SRC,
  input  logic [N_CDB-1:0]        iCDB_VALID,
  input  logic [N_CDB-1:0]        iCDB_WRITEBACK,
  input  logic [N_CDB*REG_W-1:0]  iCDB_REGNAME,
  input  logic [N_CDB*DATA_W-1:0] iCDB_DATA,
  input  logic [PTR_W-1:0]        iEX_EXECUTION_POINTER,
  output logic                    oINFO_ENTRY_VALID,
  output logic                    oINFO_MATCHING,
  output logic [CMD_W-1:0]        oINFO_CMD,
  output logic [N_SRC-1:0]        oINFO_SRC_VALID,
  output logic [N_SRC-1:0]        oINFO_SRC_SYSREG,
  output logic [N_SRC*DATA_W-1:0] oINFO_SRC,
  output logic [REG_W-1:0]        oINFO_DEST_REGNAME,
  output logic                    oINFO_DEST_SYSREG,
  output logic [TAG_W-1:0]        oINFO_COMMIT_TAG,
  output logic [31:0]             oINFO_PC
`ifdef RS_ENTRY_AGE_EN
  ,
  output logic [7:0]              oINFO_AGE
`endif
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] WAIT  = 1'b1;
  logic [0:0]              state;
  logic [CMD_W-1:0]        cmd;
  logic [REG_W-1:0]        dest_regname;
  logic                    dest_sysreg;
  logic [TAG_W-1:0]        commit_tag;
  logic [31:0]             pc;
  logic [PTR_W-1:0]        ex_pointer;
  logic                    matched;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_sysreg;
  logic [N_SRC*DATA_W-1:0] src;
  logic [N_SRC-1:0]        hit;
  logic [N_SRC*DATA_W-1:0] hit_data;
  logic [REG_W-1:0]        lookup;
  logic                    clear;
  assign clear = !inRESET || iREMOVE_VALID || iEXOUT_VALID;
  // Awaited regname comes from the registration bus while empty, from the stored source while waiting.
  always_comb begin
    hit = '0;
    hit_data = '0;
    lookup = '0;
    for (int i = 0; i < N_SRC; i++) begin
      lookup = state == EMPTY ? iREGIST_SRC[i*DATA_W +: REG_W] : src[i*DATA_W +: REG_W];
      for (int k = N_CDB - 1; k >= 0; k--)
        if (iCDB_VALID[k] && iCDB_WRITEBACK[k] && iCDB_REGNAME[k*REG_W +: REG_W] == lookup) begin
          hit[i] = 1'b1;
          hit_data[i*DATA_W +: DATA_W] = iCDB_DATA[k*DATA_W +: DATA_W];
        end
    end
  end
  always_ff @(posedge iCLOCK) begin
    if (clear) begin
      state <= EMPTY;
      cmd <= '0;
      dest_regname <= '0;
      dest_sysreg <= 1'b0;
      commit_tag <= '0;
      pc <= '0;
      ex_pointer <= '0;
      matched <= 1'b0;
      src_valid <= '0;
      src_sysreg <= '0;
      src <= '0;
    end else if (state == EMPTY) begin
      if (iREGIST_VALID) begin
        state <= WAIT;
        cmd <= iREGIST_CMD;
        dest_regname <= iREGIST_DEST_REGNAME;
        dest_sysreg <= iREGIST_DEST_SYSREG;
        commit_tag <= iREGIST_COMMIT_TAG;
        pc <= iREGIST_PC;
        ex_pointer <= iREGIST_EX_POINTER;
        matched <= iREGIST_EX_POINTER == iEX_EXECUTION_POINTER;
        src_sysreg <= iREGIST_SRC_SYSREG;
        for (int i = 0; i < N_SRC; i++) begin
          src_valid[i] <= iREGIST_SRC_SYSREG[i] || iREGIST_SRC_VALID[i] || hit[i];
          src[i*DATA_W +: DATA_W] <= (iREGIST_SRC_SYSREG[i] || iREGIST_SRC_VALID[i] || !hit[i]) ?
            iREGIST_SRC[i*DATA_W +: DATA_W] : hit_data[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      if (ex_pointer == iEX_EXECUTION_POINTER) matched <= 1'b1;
      for (int i = 0; i < N_SRC; i++)
        if (!src_valid[i] && hit[i]) begin
          src_valid[i] <= 1'b1;
          src[i*DATA_W +: DATA_W] <= hit_data[i*DATA_W +: DATA_W];
        end
    end
  end
`ifdef RS_ENTRY_AGE_EN
  logic [7:0] age;
  always_ff @(posedge iCLOCK) begin
    if (clear || state == EMPTY) age <= '0;
    else if (age != 8'hff) age <= age + 8'd1;
  end
  assign oINFO_AGE = age;
`endif
  assign oINFO_ENTRY_VALID  = state == WAIT;
  assign oINFO_MATCHING     = state == WAIT && &src_valid && matched;
  assign oINFO_CMD          = cmd;
  assign oINFO_SRC_VALID    = src_valid;
  assign oINFO_SRC_SYSREG   = src_sysreg;
  assign oINFO_SRC          = src;
  assign oINFO_DEST_REGNAME = dest_regname;
  assign oINFO_DEST_SYSREG  = dest_sysreg;
  assign oINFO_COMMIT_TAG   = commit_tag;
  assign oINFO_PC           = pc;
endmodule

// File: tb/tb_reservation_station_entry_gen.sv
// tb_reservation_station_entry_gen: directed and random checks of the RS entry against a behavioural model.
module tb_reservation_station_entry_gen;
  localparam int DW = 32, NS = 2, NC = 3, RW = 6, TW = 6, CW = 5, PW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, remove, exout, rv;
  logic [CW-1:0] r_cmd;
  logic [RW-1:0] r_dreg;
  logic r_dsys;
  logic [TW-1:0] r_tag;
  logic [31:0] r_pc;
  logic [PW-1:0] r_ptr, ex_ptr;
  logic [NS-1:0] r_sv, r_ss;
  logic [NS*DW-1:0] r_src;
  logic [NC-1:0] c_v, c_wb;
  logic [NC*RW-1:0] c_reg;
  logic [NC*DW-1:0] c_data;
  logic o_ev, o_m, o_dsys;
  logic [CW-1:0] o_cmd;
  logic [NS-1:0] o_sv, o_ss;
  logic [NS*DW-1:0] o_src;
  logic [RW-1:0] o_dreg;
  logic [TW-1:0] o_tag;
  logic [31:0] o_pc;
  logic [7:0] o_age;
  reservation_station_entry_gen dut (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE_VALID(remove), .iEXOUT_VALID(exout),
    .iREGIST_VALID(rv), .iREGIST_CMD(r_cmd), .iREGIST_DEST_REGNAME(r_dreg),
    .iREGIST_DEST_SYSREG(r_dsys), .iREGIST_COMMIT_TAG(r_tag), .iREGIST_PC(r_pc),
    .iREGIST_EX_POINTER(r_ptr), .iREGIST_SRC_VALID(r_sv), .iREGIST_SRC_SYSREG(r_ss),
    .iREGIST_SRC(r_src), .iCDB_VALID(c_v), .iCDB_WRITEBACK(c_wb), .iCDB_REGNAME(c_reg),
    .iCDB_DATA(c_data), .iEX_EXECUTION_POINTER(ex_ptr), .oINFO_ENTRY_VALID(o_ev),
    .oINFO_MATCHING(o_m), .oINFO_CMD(o_cmd), .oINFO_SRC_VALID(o_sv), .oINFO_SRC_SYSREG(o_ss),
    .oINFO_SRC(o_src), .oINFO_DEST_REGNAME(o_dreg), .oINFO_DEST_SYSREG(o_dsys),
    .oINFO_COMMIT_TAG(o_tag), .oINFO_PC(o_pc)
`ifdef RS_ENTRY_AGE_EN
    , .oINFO_AGE(o_age)
`endif
  );
  int tests = 0, fails = 0;
  bit m_v, m_matched, m_dsys;
  logic [CW-1:0] m_cmd;
  logic [RW-1:0] m_dreg;
  logic [TW-1:0] m_tag;
  logic [31:0] m_pc;
  logic [PW-1:0] m_ptr;
  bit m_sv[NS], m_ss[NS];
  logic [DW-1:0] m_src[NS];
  int m_age;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit cdb_find(input logic [RW-1:0] r, output logic [DW-1:0] d);
    d = '0;
    for (int k = 0; k < NC; k++)
      if (c_v[k] && c_wb[k] && c_reg[k*RW +: RW] == r) begin
        d = c_data[k*DW +: DW];
        return 1'b1;
      end
    return 1'b0;
  endfunction
  task automatic model_clear();
    m_v = 0; m_matched = 0; m_dsys = 0; m_cmd = '0; m_dreg = '0; m_tag = '0; m_pc = '0; m_ptr = '0; m_age = 0;
    for (int i = 0; i < NS; i++) begin m_sv[i] = 0; m_ss[i] = 0; m_src[i] = '0; end
  endtask
  task automatic model_step();
    logic [DW-1:0] d;
    bit h;
    if (!rst_n || remove || exout) model_clear();
    else if (!m_v) begin
      if (rv) begin
        m_v = 1; m_cmd = r_cmd; m_dreg = r_dreg; m_dsys = r_dsys; m_tag = r_tag; m_pc = r_pc;
        m_ptr = r_ptr; m_matched = (r_ptr == ex_ptr); m_age = 0;
        for (int i = 0; i < NS; i++) begin
          m_ss[i] = r_ss[i];
          m_src[i] = r_src[i*DW +: DW];
          m_sv[i] = r_ss[i] || r_sv[i];
          if (!m_sv[i]) begin
            h = cdb_find(m_src[i][RW-1:0], d);
            if (h) begin m_sv[i] = 1; m_src[i] = d; end
          end
        end
      end
    end else begin
      if (m_ptr == ex_ptr) m_matched = 1;
      m_age = m_age < 255 ? m_age + 1 : 255;
      for (int i = 0; i < NS; i++)
        if (!m_sv[i]) begin
          h = cdb_find(m_src[i][RW-1:0], d);
          if (h) begin m_sv[i] = 1; m_src[i] = d; end
        end
    end
  endtask
  task automatic check_all();
    logic [NS-1:0] esv, ess;
    logic [NS*DW-1:0] esrc;
    bit all_v;
    all_v = 1;
    for (int i = 0; i < NS; i++) begin
      esv[i] = m_sv[i]; ess[i] = m_ss[i]; esrc[i*DW +: DW] = m_src[i];
      if (!m_sv[i]) all_v = 0;
    end
    chk("entry_valid", 64'(o_ev), 64'(m_v));
    chk("matching", 64'(o_m), 64'(m_v && m_matched && all_v));
    chk("cmd", 64'(o_cmd), 64'(m_cmd));
    chk("src_valid", 64'(o_sv), 64'(esv));
    chk("src_sysreg", 64'(o_ss), 64'(ess));
    chk("src", o_src, esrc);
    chk("dest_regname", 64'(o_dreg), 64'(m_dreg));
    chk("dest_sysreg", 64'(o_dsys), 64'(m_dsys));
    chk("commit_tag", 64'(o_tag), 64'(m_tag));
    chk("pc", 64'(o_pc), 64'(m_pc));
`ifdef RS_ENTRY_AGE_EN
    chk("age", 64'(o_age), 64'(m_age));
`endif
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic idle();
    remove = 0; exout = 0; rv = 0; r_cmd = '0; r_dreg = '0; r_dsys = 0; r_tag = '0; r_pc = '0;
    r_ptr = ex_ptr; r_sv = '0; r_ss = '0; r_src = '0; c_v = '0; c_wb = '0; c_reg = '0; c_data = '0;
  endtask
  task automatic regist(input logic [NS-1:0] sv, input logic [DW-1:0] s0, input logic [DW-1:0] s1);
    idle();
    rv = 1; r_cmd = 5'h0a; r_dreg = 6'h21; r_dsys = 1; r_tag = 6'h15; r_pc = 32'h0000_1000;
    r_sv = sv; r_src = {s1, s0};
  endtask
  task automatic flush();
    idle(); exout = 1; cycle(); idle();
  endtask
  initial begin
    ex_ptr = '0; rst_n = 0; idle(); model_clear();
    cycle(); cycle();
    chk("reset_valid", 64'(o_ev), 64'd0);
    chk("reset_src", o_src, 64'd0);
    rst_n = 1;
    regist(2'b01, 32'h11, 32'h5); cycle();
    chk("r27_wait_match", 64'(o_m), 64'd0);
    idle(); cycle();
    c_v = 3'b010; c_wb = 3'b010; c_reg = {6'd0, 6'd5, 6'd0}; c_data = {32'h0, 32'hab, 32'h0}; cycle();
    chk("r27_match", 64'(o_m), 64'd1);
    chk("r27_src1", 64'(o_src[63:32]), 64'hab);
    flush();
    regist(2'b10, 32'h3, 32'h44);
    c_v = 3'b101; c_wb = 3'b101; c_reg = {6'd3, 6'd0, 6'd3}; c_data = {32'h2, 32'h0, 32'h1}; cycle();
    chk("r28_sv", 64'(o_sv), 64'h3);
    chk("r28_src0", 64'(o_src[31:0]), 64'h1);
    flush();
    regist(2'b10, 32'h5, 32'h44); cycle();
    idle(); c_v = 3'b001; c_wb = 3'b000; c_reg = {12'd0, 6'd5}; c_data = {64'd0, 32'h77}; cycle();
    chk("r29_sv0", 64'(o_sv[0]), 64'd0);
    chk("r29_match", 64'(o_m), 64'd0);
    flush();
    ex_ptr = 4'd6; regist(2'b11, 32'h1, 32'h2); r_ptr = 4'd7; cycle();
    chk("r30_ptr_wait", 64'(o_m), 64'd0);
    idle(); ex_ptr = 4'd7; cycle(); cycle();
    chk("r30_ptr_hit", 64'(o_m), 64'd1);
    ex_ptr = 4'd8; cycle();
    chk("r30_sticky", 64'(o_m), 64'd1);
    flush();
    regist(2'b11, 32'h1, 32'h2); remove = 1; cycle();
    chk("r31_remove_regist", 64'(o_ev), 64'd0);
    regist(2'b11, 32'h1, 32'h2); cycle();
    chk("r31_wait", 64'(o_ev), 64'd1);
    idle(); rst_n = 0; cycle();
    chk("r31_rst_valid", 64'(o_ev), 64'd0);
    chk("r31_rst_pc", 64'(o_pc), 64'd0);
    chk("r31_rst_src", o_src, 64'd0);
    rst_n = 1;
`ifdef RS_ENTRY_AGE_EN
    regist(2'b01, 32'h1, 32'h9); cycle();
    idle();
    for (int n = 0; n < 300; n++) cycle();
    chk("r32_age_sat", 64'(o_age), 64'd255);
    flush();
    chk("r32_age_clr", 64'(o_age), 64'd0);
`endif
    for (int n = 0; n < 4000; n++) begin
      rst_n = $urandom_range(0, 63) != 0;
      remove = $urandom_range(0, 19) == 0;
      exout = $urandom_range(0, 15) == 0;
      rv = $urandom_range(0, 1) == 1;
      r_cmd = CW'($urandom); r_dreg = RW'($urandom); r_dsys = 1'($urandom);
      r_tag = TW'($urandom); r_pc = $urandom;
      if ($urandom_range(0, 3) == 0) ex_ptr = ex_ptr + 1'b1;
      r_ptr = ex_ptr + PW'($urandom_range(0, 3));
      r_sv = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        r_ss[i] = $urandom_range(0, 7) == 0;
        r_src[i*DW +: DW] = {$urandom} & 32'hffff_ffc7;
      end
      c_v = NC'($urandom); c_wb = NC'($urandom | $urandom);
      for (int k = 0; k < NC; k++) begin
        c_reg[k*RW +: RW] = RW'($urandom_range(0, 7));
        c_data[k*DW +: DW] = $urandom;
      end
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
